// File: rtl/add_serial.sv
// add_serial: multi-cycle adder/subtractor that adds CHUNK bits per clock,
// least-significant chunk first, keeping the inter-chunk carry in a register.
// Operands enter through a valid/ready handshake. The result is held in output
// registers behind a second valid/ready handshake until the consumer takes it.
// WIDTH must be an integer multiple of CHUNK.
module add_serial #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] aChunk;
    logic [CHUNK-1:0] bChunk;
    logic [CHUNK:0]   chunkSum;
    logic [WIDTH-1:0] partNext;
    logic             lastChunk;

    // Select the operand chunk addressed by the counter, add it with the held
    // carry, and splice the chunk result into the partial-sum word.
    always_comb begin
        aChunk   = '0;
        bChunk   = '0;
        partNext = part_q;
        for (int k = 0; k < NCHUNK; k++) begin
            if (cnt_q == CW'(k)) begin
                aChunk = opA_q[k*CHUNK +: CHUNK];
                bChunk = opB_q[k*CHUNK +: CHUNK];
            end
        end
        chunkSum = {1'b0, aChunk} + {1'b0, bChunk} + {{CHUNK{1'b0}}, carry_q};
        for (int k = 0; k < NCHUNK; k++) begin
            if (cnt_q == CW'(k)) begin
                partNext[k*CHUNK +: CHUNK] = chunkSum[CHUNK-1:0];
            end
        end
        lastChunk = (cnt_q == CW'(NCHUNK - 1));
    end

    // Next-state logic: accept operands in IDLE, add one chunk per RUN cycle,
    // publish the result on the last chunk, and wait in DONE for the consumer.
    always_comb begin
        state_d = state_q;
        opA_d   = opA_q;
        opB_d   = opB_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        part_d  = part_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opA_d   = A;
                    opB_d   = B ^ {WIDTH{Sub}};
                    carry_d = Cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                carry_d = chunkSum[CHUNK];
                part_d  = partNext;
                cnt_d   = cnt_q + CW'(1);
                if (lastChunk) begin
                    cnt_d   = '0;
                    sum_d   = partNext;
                    cout_d  = chunkSum[CHUNK];
                    ovf_d   = (opA_q[WIDTH-1] == opB_q[WIDTH-1]) &&
                              (partNext[WIDTH-1] != opA_q[WIDTH-1]);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset that aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            opA_q   <= '0;
            opB_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            part_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            part_q  <= part_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;

endmodule

// File: tb/tb_add_serial.sv
// tb_add_serial: self-checking bench for add_serial. It drives three instances
// (CHUNK=4, 16 and 1). Expected results come from a plain 17-bit arithmetic
// model, are queued at accept, and are compared when the DUT presents them.
module tb_add_serial;

    localparam int W    = 16;
    localparam int NDUT = 3;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic [W-1:0] aIn      [NDUT];
    logic [W-1:0] bIn      [NDUT];
    logic         cinIn    [NDUT];
    logic         subIn    [NDUT];
    logic         inValid  [NDUT];
    logic         outReady [NDUT];
    wire          inReady  [NDUT];
    wire  [W-1:0] sumOut   [NDUT];
    wire          coutOut  [NDUT];
    wire          ovfOut   [NDUT];
    wire          outValid [NDUT];

    exp_t expQ[$];
    int   total = 0;
    int   bad   = 0;
    int   lat [NDUT] = '{4, 1, 16};

    // Free-running clock with a 10 time-unit period.
    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : gDut
        localparam int CH = (g == 0) ? 4 : ((g == 1) ? 16 : 1);
        add_serial #(.WIDTH(W), .CHUNK(CH)) dut (
            .clk      (clk),
            .rst      (rst),
            .A        (aIn[g]),
            .B        (bIn[g]),
            .Cin      (cinIn[g]),
            .Sub      (subIn[g]),
            .in_valid (inValid[g]),
            .in_ready (inReady[g]),
            .Sum      (sumOut[g]),
            .Cout     (coutOut[g]),
            .Ovf      (ovfOut[g]),
            .out_valid(outValid[g]),
            .out_ready(outReady[g])
        );
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic waitEdge();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t         e;
        logic [W-1:0] bb;
        logic [W:0]   full;
        bb     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        return e;
    endfunction

    // Run one operation on DUT d, optionally holding off the consumer for
    // 'hold' cycles while poking in_valid, then check result and latency.
    task automatic applyStimulus(input int d, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub, input int hold);
        int   cycles;
        exp_t e;
        checkOutput("rdy_idle", inReady[d], 1);
        aIn[d]      = a;
        bIn[d]      = b;
        cinIn[d]    = cin;
        subIn[d]    = sub;
        inValid[d]  = 1'b1;
        outReady[d] = (hold > 0) ? 1'b0 : 1'b1;
        expQ.push_back(model(a, b, cin, sub));
        waitEdge();
        inValid[d] = 1'b0;
        aIn[d]     = W'($urandom);
        bIn[d]     = W'($urandom);
        cinIn[d]   = ~cin;
        subIn[d]   = ~sub;
        cycles     = 0;
        while (!outValid[d] && cycles < 40) begin
            checkOutput("rdy_busy", inReady[d], 0);
            waitEdge();
            cycles++;
        end
        if (!outValid[d]) begin
            checkOutput("timeout", 0, 1);
            void'(expQ.pop_front());
            return;
        end
        checkOutput("latency", cycles, lat[d]);
        for (int h = 0; h < hold; h++) begin
            checkOutput("hold_valid", outValid[d], 1);
            checkOutput("hold_sum", sumOut[d], expQ[0].sum);
            checkOutput("hold_cout", coutOut[d], expQ[0].cout);
            checkOutput("hold_ovf", ovfOut[d], expQ[0].ovf);
            checkOutput("hold_rdy", inReady[d], 0);
            inValid[d] = 1'b1;
            aIn[d]     = W'($urandom);
            waitEdge();
        end
        inValid[d]  = 1'b0;
        outReady[d] = 1'b1;
        e = expQ.pop_front();
        checkOutput("sum", sumOut[d], e.sum);
        checkOutput("cout", coutOut[d], e.cout);
        checkOutput("ovf", ovfOut[d], e.ovf);
        waitEdge();
        checkOutput("pop_valid", outValid[d], 0);
        checkOutput("pop_rdy", inReady[d], 1);
        waitEdge();
    endtask

    // Main sequence: reset, directed vectors, back-pressure, abort by reset,
    // the carry-ripple vectors on the other chunk sizes, and a few random ops.
    initial begin
        rst = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            aIn[d] = '0; bIn[d] = '0; cinIn[d] = 1'b0; subIn[d] = 1'b0;
            inValid[d] = 1'b0; outReady[d] = 1'b1;
        end
        waitEdge();
        waitEdge();
        for (int d = 0; d < NDUT; d++) begin
            checkOutput("rst_sum", sumOut[d], 0);
            checkOutput("rst_cout", coutOut[d], 0);
            checkOutput("rst_ovf", ovfOut[d], 0);
            checkOutput("rst_valid", outValid[d], 0);
            checkOutput("rst_rdy", inReady[d], 1);
        end
        rst = 1'b0;
        waitEdge();

        applyStimulus(0, 16'h0001, 16'h0002, 1'b0, 1'b0, 0);
        applyStimulus(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        applyStimulus(0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0);
        applyStimulus(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        applyStimulus(0, 16'hAAAA, 16'h5555, 1'b0, 1'b0, 0);
        applyStimulus(0, 16'h0005, 16'h0007, 1'b1, 1'b1, 0);
        applyStimulus(0, 16'h8000, 16'h0001, 1'b1, 1'b1, 0);
        applyStimulus(0, 16'h1234, 16'h4321, 1'b0, 1'b0, 3);

        aIn[0] = 16'h1111; bIn[0] = 16'h2222; cinIn[0] = 1'b0; subIn[0] = 1'b0;
        inValid[0] = 1'b1;
        waitEdge();
        inValid[0] = 1'b0;
        waitEdge();
        rst = 1'b1;
        waitEdge();
        rst = 1'b0;
        checkOutput("abort_valid", outValid[0], 0);
        checkOutput("abort_sum", sumOut[0], 0);
        checkOutput("abort_cout", coutOut[0], 0);
        checkOutput("abort_ovf", ovfOut[0], 0);
        checkOutput("abort_rdy", inReady[0], 1);
        for (int i = 0; i < 6; i++) begin
            waitEdge();
            checkOutput("abort_quiet", outValid[0], 0);
        end
        applyStimulus(0, 16'h0001, 16'h0002, 1'b0, 1'b0, 0);

        for (int d = 1; d < NDUT; d++) begin
            applyStimulus(d, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
            applyStimulus(d, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0);
        end
        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < 4; i++) begin
                applyStimulus(d, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                              (i == 1) ? 2 : 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
